// File: rtl/mcb_port_arbiter.sv
// mcb_port_arbiter: shares MCB user port p0 between cache line
// write-back/fill and video line fetch, one command at a time.
module mcb_port_arbiter #(
  parameter int BEATS    = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c_wr_req,
  input  logic         c_rd_req,
  input  logic [15:0]  c_waddr,
  input  logic [15:0]  c_raddr,
  output logic         c_wr_busy,
  output logic         c_rd_busy,
  output logic         c_done,
  output logic         c_buf_en,
  output logic         c_buf_we,
  output logic [$clog2(BEATS)-1:0] c_buf_addr,
  output logic [127:0] c_buf_wdata,
  input  logic [127:0] c_buf_rdata,
  input  logic         v_req,
  input  logic [15:0]  v_addr,
  output logic         v_ack,
  output logic         v_valid,
  output logic [127:0] v_data,
  output logic         v_last,
  output logic         cmd_en,
  output logic [2:0]   cmd_instr,
  output logic [5:0]   cmd_bl,
  output logic [29:0]  cmd_byte_addr,
  input  logic         cmd_full,
  output logic         wr_en,
  output logic [127:0] wr_data,
  input  logic         wr_empty,
  output logic         rd_en,
  input  logic [127:0] rd_data,
  input  logic         rd_empty
);

  localparam int BW = $clog2(BEATS);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE, GAP, WFILL, WCMD, WDRAIN, RCMD, READ
  } state_t;

  state_t        state;
  logic          tgt_v;
  logic [15:0]   line;
  logic [BW-1:0] cnt;
  logic [WW-1:0] wait_cnt;

  logic g_vf, g_wc, g_w, g_r, g_v;

  // Video starvation guard overrides the cache priority.
  assign g_vf = v_req && (wait_cnt == WMAX);
  assign g_wc = c_wr_req && wr_empty;
  assign g_w  = !g_vf && g_wc;
  assign g_r  = !g_vf && !g_wc && c_rd_req;
  assign g_v  = g_vf || (v_req && !g_wc && !c_rd_req);

  assign cmd_bl        = 6'(BEATS - 1);
  assign cmd_byte_addr = {6'b0, line, 8'b0};
  assign wr_data       = c_buf_rdata;
  assign rd_en         = (state == READ) && !rd_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tgt_v       <= 1'b0;
      line        <= '0;
      cnt         <= '0;
      wait_cnt    <= '0;
      c_wr_busy   <= 1'b0;
      c_rd_busy   <= 1'b0;
      c_done      <= 1'b0;
      c_buf_en    <= 1'b0;
      c_buf_we    <= 1'b0;
      c_buf_addr  <= '0;
      c_buf_wdata <= '0;
      v_ack       <= 1'b0;
      v_valid     <= 1'b0;
      v_data      <= '0;
      v_last      <= 1'b0;
      cmd_en      <= 1'b0;
      cmd_instr   <= 3'b000;
      wr_en       <= 1'b0;
    end else begin
      cmd_en   <= 1'b0;
      v_ack    <= 1'b0;
      c_done   <= 1'b0;
      wr_en    <= 1'b0;
      v_valid  <= 1'b0;
      v_last   <= 1'b0;
      c_buf_en <= 1'b0;
      c_buf_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!v_req || g_v) begin
            wait_cnt <= '0;
          end else if ((g_w || g_r) && wait_cnt != WMAX) begin
            wait_cnt <= wait_cnt + WW'(1);
          end
          unique case (1'b1)
            g_w: begin
              c_wr_busy <= 1'b1;
              line      <= c_waddr;
              cmd_instr <= 3'b000;
              state     <= WFILL;
            end
            g_r: begin
              c_rd_busy <= 1'b1;
              line      <= c_raddr;
              tgt_v     <= 1'b0;
              cmd_instr <= 3'b001;
              state     <= RCMD;
            end
            g_v: begin
              line      <= v_addr;
              tgt_v     <= 1'b1;
              cmd_instr <= 3'b001;
              state     <= RCMD;
            end
            default: ;
          endcase
        end
        GAP: state <= IDLE;
        WFILL: begin
          // Buffer read data lags c_buf_en by one cycle.
          wr_en <= c_buf_en;
          if (c_buf_en && c_buf_addr == LAST) begin
            state <= WCMD;
          end else begin
            c_buf_en   <= 1'b1;
            c_buf_addr <= c_buf_en ? c_buf_addr + BW'(1) : '0;
          end
        end
        WCMD: begin
          if (!cmd_full) begin
            cmd_en <= 1'b1;
            state  <= WDRAIN;
          end
        end
        WDRAIN: begin
          if (wr_empty) begin
            c_done    <= 1'b1;
            c_wr_busy <= 1'b0;
            state     <= GAP;
          end
        end
        RCMD: begin
          if (!cmd_full) begin
            cmd_en <= 1'b1;
            v_ack  <= tgt_v;
            cnt    <= '0;
            state  <= READ;
          end
        end
        READ: begin
          if (rd_en) begin
            if (tgt_v) begin
              v_valid <= 1'b1;
              v_data  <= rd_data;
              v_last  <= (cnt == LAST);
            end else begin
              c_buf_en    <= 1'b1;
              c_buf_we    <= 1'b1;
              c_buf_addr  <= cnt;
              c_buf_wdata <= rd_data;
            end
            cnt <= cnt + BW'(1);
            if (cnt == LAST) begin
              c_done    <= !tgt_v;
              c_rd_busy <= 1'b0;
              state     <= GAP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// tb_mcb_port_arbiter: directed checks of the MCB port arbiter
// against a small line-buffer and MCB FIFO model.
module tb_mcb_port_arbiter;

  localparam int BEATS = 16;

  logic clk = 1'b0;
  logic rst;
  logic c_wr_req, c_rd_req, v_req, cmd_full;
  logic [15:0] c_waddr, c_raddr, v_addr;
  logic c_wr_busy, c_rd_busy, c_done;
  logic c_buf_en, c_buf_we;
  logic [3:0] c_buf_addr;
  logic [127:0] c_buf_wdata, c_buf_rdata;
  logic v_ack, v_valid, v_last;
  logic [127:0] v_data;
  logic cmd_en;
  logic [2:0] cmd_instr;
  logic [5:0] cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic wr_en, wr_empty, rd_en, rd_empty;
  logic [127:0] wr_data, rd_data;

  mcb_port_arbiter #(.BEATS(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .c_wr_req(c_wr_req), .c_rd_req(c_rd_req),
    .c_waddr(c_waddr), .c_raddr(c_raddr),
    .c_wr_busy(c_wr_busy), .c_rd_busy(c_rd_busy),
    .c_done(c_done), .c_buf_en(c_buf_en),
    .c_buf_we(c_buf_we), .c_buf_addr(c_buf_addr),
    .c_buf_wdata(c_buf_wdata), .c_buf_rdata(c_buf_rdata),
    .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack),
    .v_valid(v_valid), .v_data(v_data), .v_last(v_last),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr),
    .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_full(cmd_full), .wr_en(wr_en),
    .wr_data(wr_data), .wr_empty(wr_empty),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [127:0] lbuf [BEATS];
  logic [127:0] rmem [64];
  logic [5:0] wp, rp;
  int wcnt;
  logic wdrain, bub, bub_on;

  assign wr_empty = (wcnt == 0);
  assign rd_empty = (wp == rp) || bub;
  assign rd_data  = rmem[rp];

  // Line buffer with 1-cycle read latency and an MCB FIFO model.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= 0;
      wdrain <= 1'b0;
      wp <= '0;
      rp <= '0;
      bub <= 1'b0;
      c_buf_rdata <= '0;
    end else begin
      bub <= bub_on && !bub;
      if (c_buf_en && !c_buf_we) c_buf_rdata <= lbuf[c_buf_addr];
      if (wr_en) wcnt <= wcnt + 1;
      else if (wdrain && wcnt != 0) wcnt <= wcnt - 1;
      if (cmd_en && cmd_instr == 3'b000) wdrain <= 1'b1;
      else if (wcnt == 0) wdrain <= 1'b0;
      if (cmd_en && cmd_instr == 3'b001) begin
        for (int i = 0; i < BEATS; i++)
          rmem[wp + 6'(i)] <= {cmd_byte_addr[23:8], 96'h0, 16'(i)};
        wp <= wp + 6'(BEATS);
      end
      if (rd_en) rp <= rp + 6'd1;
    end
  end

  logic [127:0] wlog [$];
  int wcyc [$];
  logic [3:0] flog_a [$];
  logic [127:0] flog_d [$];
  logic [127:0] vlog_d [$];
  logic vlog_l [$];
  logic [2:0] cq_i [$];
  logic [29:0] cq_a [$];
  logic [5:0] cq_bl [$];
  logic cq_ack [$];
  int cq_cyc [$];
  int done_cnt = 0;
  logic done_we = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) begin
      wlog.push_back(wr_data);
      wcyc.push_back(cyc);
    end
    if (c_buf_we) begin
      flog_a.push_back(c_buf_addr);
      flog_d.push_back(c_buf_wdata);
    end
    if (v_valid) begin
      vlog_d.push_back(v_data);
      vlog_l.push_back(v_last);
    end
    if (cmd_en) begin
      cq_i.push_back(cmd_instr);
      cq_a.push_back(cmd_byte_addr);
      cq_bl.push_back(cmd_bl);
      cq_ack.push_back(v_ack);
      cq_cyc.push_back(cyc);
    end
    if (c_done) begin
      done_cnt <= done_cnt + 1;
      done_we <= c_buf_we;
    end
  end

  logic [47:0] ctl;
  assign ctl = {c_wr_busy, c_rd_busy, c_done, c_buf_en, c_buf_we,
                c_buf_addr, v_ack, v_valid, v_last, cmd_en,
                cmd_instr, cmd_byte_addr, wr_en, rd_en};

  function automatic int cur(input int sel);
    case (sel)
      0: return done_cnt;
      1: return cq_i.size();
      2: return vlog_d.size();
      default: return wlog.size();
    endcase
  endfunction

  task automatic wait_ev(input int sel, input int n, input string tag);
    int k = 0;
    while (cur(sel) < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 128'(cur(sel) >= n), 128'd1);
  endtask

  task automatic check_wb(input int n0, input string tag);
    int e = 0;
    for (int k = 0; k < BEATS; k++)
      if (wlog[n0 + k] !== 128'(k)) e++;
    chk({tag, "_n"}, 128'(wlog.size() - n0), 128'd16);
    chk({tag, "_d"}, 128'(e), 128'd0);
  endtask

  task automatic check_fill(input int f0, input logic [15:0] a,
                            input string tag);
    int e = 0;
    logic [127:0] ex;
    for (int k = 0; k < BEATS; k++) begin
      ex = {a, 96'h0, 16'(k)};
      if (flog_a[f0 + k] !== 4'(k) || flog_d[f0 + k] !== ex) e++;
    end
    chk({tag, "_n"}, 128'(flog_a.size() - f0), 128'd16);
    chk({tag, "_d"}, 128'(e), 128'd0);
  endtask

  task automatic check_vid(input int v0, input logic [15:0] a,
                           input string tag);
    int e = 0;
    int nl = 0;
    logic [127:0] ex;
    for (int k = 0; k < BEATS; k++) begin
      ex = {a, 96'h0, 16'(k)};
      if (vlog_d[v0 + k] !== ex) e++;
      if (vlog_l[v0 + k]) nl++;
    end
    chk({tag, "_n"}, 128'(vlog_d.size() - v0), 128'd16);
    chk({tag, "_d"}, 128'(e), 128'd0);
    chk({tag, "_nlast"}, 128'(nl), 128'd1);
    chk({tag, "_last"}, 128'(vlog_l[v0 + 15]), 128'd1);
  endtask

  int n0, c0, d0, f0, v0, ak, k;
  logic found;

  initial begin
    rst = 1'b0;
    c_wr_req = 1'b0;
    c_rd_req = 1'b0;
    v_req = 1'b0;
    cmd_full = 1'b0;
    bub_on = 1'b0;
    c_waddr = '0;
    c_raddr = '0;
    v_addr = '0;
    for (int i = 0; i < BEATS; i++) lbuf[i] = 128'(i);
    #1;
    chk("rst_ctl", 128'(ctl), 128'd0);
    chk("rst_bwd", c_buf_wdata, 128'd0);
    chk("rst_vd", v_data, 128'd0);
    chk("rst_bl", 128'(cmd_bl), 128'd15);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // write-back
    @(negedge clk);
    n0 = wlog.size(); c0 = cq_i.size(); d0 = done_cnt;
    c_waddr = 16'h1234;
    c_wr_req = 1'b1;
    wait_ev(0, d0 + 1, "wb_wait");
    c_wr_req = 1'b0;
    check_wb(n0, "wb");
    chk("wb_ncmd", 128'(cq_i.size() - c0), 128'd1);
    chk("wb_instr", 128'(cq_i[c0]), 128'd0);
    chk("wb_addr", 128'(cq_a[c0]), 128'h00123400);
    chk("wb_bl", 128'(cq_bl[c0]), 128'd15);
    chk("wb_lat", 128'(cq_cyc[c0] - wcyc[n0]), 128'd16);
    chk("wb_done_we", 128'(done_we), 128'd0);

    // fill with rd_empty bubbles
    f0 = flog_a.size(); c0 = cq_i.size(); d0 = done_cnt;
    bub_on = 1'b1;
    c_raddr = 16'h00AB;
    c_rd_req = 1'b1;
    wait_ev(0, d0 + 1, "fill_wait");
    c_rd_req = 1'b0;
    bub_on = 1'b0;
    check_fill(f0, 16'h00AB, "fill");
    chk("fill_instr", 128'(cq_i[c0]), 128'd1);
    chk("fill_addr", 128'(cq_a[c0]), 128'h0000AB00);
    chk("fill_ack", 128'(cq_ack[c0]), 128'd0);
    chk("fill_done_we", 128'(done_we), 128'd1);

    // all three requesters at once
    c0 = cq_i.size(); d0 = done_cnt; v0 = vlog_d.size();
    c_waddr = 16'h1111; c_raddr = 16'h2222; v_addr = 16'h0055;
    c_wr_req = 1'b1; c_rd_req = 1'b1; v_req = 1'b1;
    wait_ev(0, d0 + 1, "pri_w_wait");
    c_wr_req = 1'b0;
    wait_ev(0, d0 + 2, "pri_r_wait");
    c_rd_req = 1'b0;
    wait_ev(1, c0 + 3, "pri_v_wait");
    v_req = 1'b0;
    wait_ev(2, v0 + 16, "pri_vb_wait");
    chk("pri_0", 128'({cq_i[c0], cq_a[c0]}), 128'({3'd0, 30'h00111100}));
    chk("pri_1", 128'({cq_i[c0+1], cq_ack[c0+1], cq_a[c0+1]}),
        128'({3'd1, 1'b0, 30'h00222200}));
    chk("pri_2", 128'({cq_i[c0+2], cq_ack[c0+2], cq_a[c0+2]}),
        128'({3'd1, 1'b1, 30'h00005500}));
    check_vid(v0, 16'h0055, "pri_vid");

    // starvation guard
    @(negedge clk);
    c0 = cq_i.size(); d0 = done_cnt; v0 = vlog_d.size();
    c_raddr = 16'h0300; v_addr = 16'h0077;
    c_rd_req = 1'b1; v_req = 1'b1;
    wait_ev(1, c0 + 5, "starve_wait");
    c_rd_req = 1'b0; v_req = 1'b0;
    wait_ev(2, v0 + 16, "starve_vb_wait");
    ak = 0;
    for (int i = 0; i < 4; i++) if (cq_ack[c0 + i]) ak++;
    chk("starve_cache_acks", 128'(ak), 128'd0);
    chk("starve_vack", 128'(cq_ack[c0 + 4]), 128'd1);
    chk("starve_vaddr", 128'(cq_a[c0 + 4]), 128'h00007700);
    chk("starve_ndone", 128'(done_cnt - d0), 128'd4);
    check_vid(v0, 16'h0077, "starve_vid");

    // cmd_full stall on write
    @(negedge clk);
    n0 = wlog.size(); c0 = cq_i.size(); d0 = done_cnt;
    cmd_full = 1'b1;
    c_waddr = 16'h0ABC;
    c_wr_req = 1'b1;
    wait_ev(3, n0 + 16, "cfw_fill_wait");
    repeat (10) @(negedge clk);
    chk("cfw_stall", 128'(cq_i.size() - c0), 128'd0);
    chk("cfw_busy", 128'(c_wr_busy), 128'd1);
    cmd_full = 1'b0;
    wait_ev(0, d0 + 1, "cfw_wait");
    c_wr_req = 1'b0;
    chk("cfw_ncmd", 128'(cq_i.size() - c0), 128'd1);
    chk("cfw_addr", 128'(cq_a[c0]), 128'h000ABC00);
    check_wb(n0, "cfw");

    // cmd_full stall on read
    f0 = flog_a.size(); c0 = cq_i.size(); d0 = done_cnt;
    cmd_full = 1'b1;
    c_raddr = 16'h0CDE;
    c_rd_req = 1'b1;
    repeat (12) @(negedge clk);
    chk("cfr_stall", 128'(cq_i.size() - c0), 128'd0);
    chk("cfr_busy", 128'(c_rd_busy), 128'd1);
    cmd_full = 1'b0;
    wait_ev(0, d0 + 1, "cfr_wait");
    c_rd_req = 1'b0;
    chk("cfr_ncmd", 128'(cq_i.size() - c0), 128'd1);
    check_fill(f0, 16'h0CDE, "cfr");

    // reset in the middle of WFILL
    d0 = done_cnt;
    c_waddr = 16'h0BEE;
    c_wr_req = 1'b1;
    found = 1'b0;
    k = 0;
    while (!found && k < 200) begin
      @(negedge clk);
      k++;
      if (c_buf_en && c_buf_addr == 4'd7) found = 1'b1;
    end
    chk("mrst_seen", 128'(found), 128'd1);
    rst = 1'b0;
    #1;
    chk("mrst_ctl", 128'(ctl), 128'd0);
    repeat (2) @(negedge clk);
    n0 = wlog.size(); c0 = cq_i.size();
    rst = 1'b1;
    wait_ev(0, d0 + 1, "mrst_wait");
    c_wr_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("mrst_ndone", 128'(done_cnt - d0), 128'd1);
    chk("mrst_ncmd", 128'(cq_i.size() - c0), 128'd1);
    chk("mrst_addr", 128'(cq_a[c0]), 128'h000BEE00);
    check_wb(n0, "mrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcb_port_arbiter.md
# mcb_port_arbiter

Sequencer and arbiter for the single 128-bit LPDDR MCB user port (p0), shared between the CPU cache and a video line-fetch requester. The cache side moves 256-byte lines, 16 beats of 128 bits, out of and into the cache line buffer. The video side reads 256-byte lines into a display line FIFO. The block sits in the memory-clock domain between the cache/video logic and the MCB port, and replaces the ad-hoc port FSM in the top level.

## Interface
Parameters:
- BEATS, 16: beats per line transfer; `cmd_bl = BEATS-1`; beat counter is `$clog2(BEATS)` bits.
- MAX_WAIT, 4: consecutive cache grants allowed while `v_req` is pending before video is forced.

Ports:
- clk  in  1  memory clock (100 MHz); all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- c_wr_req  in  1  level: dirty line in buffer awaits write-back.
- c_rd_req  in  1  level: line fill requested.
- c_waddr  in  16  line address (byte addr bits 23:8) for write-back.
- c_raddr  in  16  line address for fill.
- c_wr_busy  out  1  write-back in progress.
- c_rd_busy  out  1  fill in progress.
- c_done  out  1  1-cycle pulse when a cache operation completes.
- c_buf_en  out  1  line-buffer access strobe.
- c_buf_we  out  1  line-buffer write (fill).
- c_buf_addr  out  4  line-buffer beat index.
- c_buf_wdata  out  128  fill data to line buffer.
- c_buf_rdata  in  128  line-buffer read data, valid 1 cycle after `c_buf_en`.
- v_req  in  1  level: video line wanted; `v_addr` stable while high.
- v_addr  in  16  video line address.
- v_ack  out  1  1-cycle pulse when the video read command is issued.
- v_valid  out  1  video beat valid.
- v_data  out  128  video beat data.
- v_last  out  1  with the final `v_valid` of a line.
- cmd_en  out  1  MCB command strobe.
- cmd_instr  out  3  000 = write, 001 = read.
- cmd_bl  out  6  constant `BEATS-1`.
- cmd_byte_addr  out  30  `{6'b0, line_addr, 8'b0}`.
- cmd_full  in  1  MCB command FIFO full.
- wr_en  out  1  MCB write-FIFO push.
- wr_data  out  128  `c_buf_rdata`, passed through combinationally.
- wr_empty  in  1  MCB write FIFO empty.
- rd_en  out  1  MCB read-FIFO pop.
- rd_data  in  128  read-FIFO head, valid when `~rd_empty`.
- rd_empty  in  1  MCB read FIFO empty.

## Operation
- States: IDLE, GAP, WFILL, WCMD, WDRAIN, RCMD, READ.
- Arbitration happens in IDLE only, highest priority first:
  - (a) video, if `v_req` and `wait_cnt == MAX_WAIT`;
  - (b) cache write, if `c_wr_req & wr_empty`;
  - (c) cache read, if `c_rd_req`;
  - (d) video, if `v_req`.
- `wait_cnt` increments on each cache grant while `v_req` is high, saturating at MAX_WAIT. It clears on a video grant or whenever `v_req` is low in IDLE.
- Write grant:
  - Set `c_wr_busy`, latch `c_waddr`, move to WFILL.
  - WFILL: `c_buf_en` is high for BEATS consecutive cycles with `c_buf_addr` 0..BEATS-1. `wr_en` follows one cycle later, also for BEATS cycles.
  - WCMD: `cmd_en` is asserted for exactly one cycle when `~cmd_full`, with `instr` 000.
  - WDRAIN: wait for `wr_empty`, then pulse `c_done`, clear `c_wr_busy`, go to GAP.
- Read grant (cache or video):
  - Latch the address and a target flag, set `c_rd_busy` if the target is the cache, move to RCMD.
  - RCMD: `cmd_en` for one cycle when `~cmd_full`, `instr` 001. `v_ack` pulses with it for a video target. Then go to READ.
  - READ: `rd_en = ~rd_empty`, combinational. Each cycle with `rd_en` is one beat. The beat is registered to the target on the next cycle:
    - cache target: `c_buf_en = c_buf_we = 1`, `c_buf_addr` = beat index, `c_buf_wdata = rd_data`;
    - video target: `v_valid = 1`, `v_data = rd_data`, `v_last` on beat BEATS-1.
  - After beat BEATS-1 is popped, go to GAP. For a cache target, `c_done` pulses and `c_rd_busy` clears in the cycle the last `c_buf_we` is presented.
- GAP lasts one cycle and ignores requests, so the requester can drop its req after `c_done`. Then go to IDLE.
- Only one MCB command is outstanding at a time. No beat is ever dropped or duplicated.

## Timing
- Reset (rst low, asynchronous):
  - all outputs 0, except `cmd_bl` (constant `BEATS-1`) and `wr_data` (passes through `c_buf_rdata`);
  - state IDLE, `wait_cnt` 0.
- Release is synchronous to clk; the first grant is possible on the first edge after release.
- Reset in the middle of an operation abandons it with no `c_done`. The MCB must be reset alongside.
- Write latency, with `cmd_full` low and `wr_empty` immediate:
  - grant edge at t0;
  - `c_buf_en` over t1..t16;
  - `wr_en` over t2..t17;
  - `cmd_en` at t18;
  - `c_done` no earlier than t19.
- Read latency: `cmd_en` at t1 after grant. Beat k is delivered 1 cycle after its `rd_en`.
- `cmd_full` held high stalls WCMD/RCMD indefinitely with no other output changes.
- `rd_empty` bubbles insert gaps in `c_buf_we`/`v_valid`; order is preserved.

## Test plan
- Write-back, `c_waddr=16'h1234`, buffer beat k = k: 16 `wr_en` carrying data 0..15, then one `cmd_en` with instr 000, addr `30'h00123400`, bl 15; `c_done` after `wr_empty`.
- Fill, `c_raddr=16'h00AB`, `rd_empty` toggling every cycle: `cmd_en` with instr 001 and addr `30'h0000AB00`; 16 `c_buf_we` at addr 0..15 in order with matching data, then `c_done`.
- `c_wr_req`, `c_rd_req`, `v_req` all raised together, `MAX_WAIT=4`: grant order is write, then read, then video; `v_ack` is coincident with the third `cmd_en`.
- Cache requests issued back-to-back with `v_req` held: video is granted after exactly 4 cache operations; 16 `v_valid`, with `v_last` only on the 16th.
- `cmd_full` high for 10 cycles during WCMD and RCMD: `cmd_en` is delayed until `cmd_full` drops, is exactly one pulse, and all 16 beats are intact.
- rst asserted at WFILL beat 7: all outputs go to 0 immediately; after release, a fresh write starts at `c_buf_addr` 0 and completes normally.
